// File: rtl/skip_share_encoder_if.sv
// Handshake bundle between the skip/share encoder and its producer/consumer.
// The encoder takes the slave view; the surrounding logic takes the master view.
interface skip_share_encoder_if #(
  parameter int WIDTH_DATA = 32
);
  logic                  I_Valid;
  logic [WIDTH_DATA-1:0] I_Data;
  logic                  I_Last;
  logic                  O_In_Ready;
  logic                  I_Abort;
  logic                  O_Valid;
  logic [WIDTH_DATA-1:0] O_Data;
  logic                  O_Attrib;
  logic                  O_AuxData;
  logic                  O_Rls;
  logic                  I_Ready;

  modport slave (
    input  I_Valid, I_Data, I_Last, I_Abort, I_Ready,
    output O_In_Ready, O_Valid, O_Data, O_Attrib, O_AuxData, O_Rls
  );

  modport master (
    output I_Valid, I_Data, I_Last, I_Abort, I_Ready,
    input  O_In_Ready, O_Valid, O_Data, O_Attrib, O_AuxData, O_Rls
  );
endinterface

// File: rtl/skip_share_encoder.sv
// Buffers one block, detects shared/zero content, then emits attribute word,
// shared word or full block, and a release pulse.
//
// state    | meaning
// S_FILL   | accepting input words into the block buffer
// S_ATTR   | presenting the attribute word {Shared, NonZero, len}
// S_SHARED | presenting the single shared data word
// S_STREAM | presenting buffered words in order
// S_RLS    | one-cycle release pulse, then back to S_FILL
module skip_share_encoder #(
  parameter int WIDTH_DATA  = 32,
  parameter int DEPTH_BLOCK = 16,
  parameter int WIDTH_LEN   = $clog2(DEPTH_BLOCK) + 1
) (
  input logic                 clock,
  input logic                 reset,
  skip_share_encoder_if.slave bus
);
  localparam int WIDTH_IDX = $clog2(DEPTH_BLOCK);
  localparam logic [WIDTH_LEN-1:0] LEN_FULL = WIDTH_LEN'(DEPTH_BLOCK);

  typedef enum logic [2:0] {S_FILL, S_ATTR, S_SHARED, S_STREAM, S_RLS} state_t;

  state_t                state_q;
  logic [WIDTH_LEN-1:0]  cnt_q;
  logic [WIDTH_LEN-1:0]  rd_q;
  logic                  all_eq_q;
  logic [WIDTH_DATA-1:0] first_q;
  logic [WIDTH_DATA-1:0] buf_q [DEPTH_BLOCK];
  logic                  valid_q;
  logic                  attrib_q;
  logic                  aux_q;
  logic                  rls_q;
  logic [WIDTH_DATA-1:0] data_q;

  logic                  abort;
  logic                  in_ready;
  logic                  in_xfer;
  logic                  out_xfer;
  logic                  block_end;
  logic [WIDTH_LEN-1:0]  cnt_d;
  logic [WIDTH_LEN-1:0]  rd_d;
  logic                  all_eq_d;
  logic [WIDTH_DATA-1:0] first_d;
  logic [WIDTH_DATA-1:0] attr_d;

  assign abort     = bus.I_Abort & (state_q != S_RLS);
  assign in_ready  = (state_q == S_FILL) & ~bus.I_Abort & ~reset;
  assign in_xfer   = bus.I_Valid & in_ready;
  assign out_xfer  = valid_q & bus.I_Ready;
  assign cnt_d     = cnt_q + WIDTH_LEN'(1);
  assign rd_d      = rd_q + WIDTH_LEN'(1);
  assign first_d   = (cnt_q == '0) ? bus.I_Data : first_q;
  assign all_eq_d  = (cnt_q == '0) | (all_eq_q & (bus.I_Data == first_q));
  // A full buffer closes the block exactly like I_Last.
  assign block_end = bus.I_Last | (cnt_d == LEN_FULL);

  always_comb begin
    attr_d                  = '0;
    attr_d[WIDTH_DATA-1]    = all_eq_d;
    attr_d[WIDTH_DATA-2]    = (first_d != '0);
    attr_d[WIDTH_LEN-1:0]   = cnt_d;
  end

  always_ff @(posedge clock) begin
    if (in_xfer) begin
      buf_q[cnt_q[WIDTH_IDX-1:0]] <= bus.I_Data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || abort) begin
      state_q  <= S_FILL;
      cnt_q    <= '0;
      rd_q     <= '0;
      all_eq_q <= 1'b1;
      first_q  <= '0;
      valid_q  <= 1'b0;
      attrib_q <= 1'b0;
      aux_q    <= 1'b0;
      rls_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (in_xfer) begin
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            all_eq_q <= all_eq_d;
            if (block_end) begin
              state_q  <= S_ATTR;
              valid_q  <= 1'b1;
              attrib_q <= 1'b1;
              data_q   <= attr_d;
            end
          end
        end
        S_ATTR: begin
          if (out_xfer) begin
            attrib_q <= 1'b0;
            aux_q    <= 1'b1;
            rd_q     <= '0;
            if (all_eq_q) begin
              state_q <= S_SHARED;
              data_q  <= first_q;
            end else begin
              state_q <= S_STREAM;
              data_q  <= buf_q[0];
            end
          end
        end
        S_SHARED: begin
          if (out_xfer) begin
            state_q <= S_RLS;
            valid_q <= 1'b0;
            aux_q   <= 1'b0;
            data_q  <= '0;
            rls_q   <= 1'b1;
          end
        end
        S_STREAM: begin
          if (out_xfer) begin
            if (rd_d == cnt_q) begin
              state_q <= S_RLS;
              valid_q <= 1'b0;
              aux_q   <= 1'b0;
              data_q  <= '0;
              rls_q   <= 1'b1;
            end else begin
              rd_q   <= rd_d;
              data_q <= buf_q[rd_d[WIDTH_IDX-1:0]];
            end
          end
        end
        S_RLS: begin
          state_q  <= S_FILL;
          rls_q    <= 1'b0;
          cnt_q    <= '0;
          all_eq_q <= 1'b1;
          first_q  <= '0;
        end
        default: state_q <= S_FILL;
      endcase
    end
  end

  // Outputs read as idle for the whole reset window, including before the first edge.
  assign bus.O_In_Ready = in_ready;
  assign bus.O_Valid    = valid_q & ~reset;
  assign bus.O_Attrib   = attrib_q & ~reset;
  assign bus.O_AuxData  = aux_q & ~reset;
  assign bus.O_Rls      = rls_q & ~reset;
  assign bus.O_Data     = reset ? '0 : data_q;
endmodule
